// File: rtl/mac_array_accum_pkg.sv
// Shared FSM encoding and arithmetic helpers for the mac_array_accum dot-product engine.
package mac_array_accum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_BIAS  = 3'd3,
    ST_OUT   = 3'd4
  } mac_state_e;

  function automatic logic signed [63:0] sat_clip(
    input logic signed [63:0] value,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    logic signed [63:0] res;
    if (value < lo) begin
      res = lo;
    end else if (value > hi) begin
      res = hi;
    end else begin
      res = value;
    end
    return res;
  endfunction

  // Accumulator must hold a full beat sum plus a sign bit of headroom.
  function automatic bit acc_w_ok(input int num_lanes, input int data_w, input int acc_w);
    return acc_w >= (2 * data_w + $clog2(num_lanes) + 1);
  endfunction

endpackage

// File: rtl/mac_array_accum_if.sv
// Beat input and result output bundle of mac_array_accum.
interface mac_array_accum_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 26
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic [NUM_LANES-1:0]        in_mask;
  logic [NUM_LANES*DATA_W-1:0] in_feature;
  logic [NUM_LANES*DATA_W-1:0] in_weight;
  logic [DATA_W-1:0]           bias;
  logic                        relu_en;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic                        out_sat;
  logic [ACC_W-1:0]            out_acc;

  modport master (
    output in_valid, in_last, in_mask, in_feature, in_weight, bias, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_acc
  );

  modport slave (
    input  in_valid, in_last, in_mask, in_feature, in_weight, bias, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_acc
  );
endinterface

// File: rtl/mac_array_accum_lane.sv
// One masked signed DATA_W x DATA_W multiplier lane (combinational).
module mac_array_accum_lane #(
  parameter int DATA_W = 8
) (
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   feature,
  input  logic signed [DATA_W-1:0]   weight,
  output logic signed [2*DATA_W-1:0] product
);

  always_comb begin
    if (en) begin
      product = (2*DATA_W)'(feature) * (2*DATA_W)'(weight);
    end else begin
      product = '0;
    end
  end

endmodule

// File: rtl/mac_array_accum.sv
// Dot-product engine: masked lane products summed per beat, accumulated with saturation,
// then biased, requantised and emitted over a valid/ready handshake.
module mac_array_accum
  import mac_array_accum_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 26,
  parameter int FRAC_SHIFT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  mac_array_accum_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(NUM_LANES) + 1;
  localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam logic signed [63:0] ACC_MIN = -(64'sd1 <<< (ACC_W - 1));
  localparam logic signed [63:0] Q_MAX_S = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
  localparam logic signed [63:0] Q_MIN_S = -(64'sd1 <<< (DATA_W - 1));
  localparam logic signed [63:0] Q_MAX_U = (64'sd1 <<< DATA_W) - 64'sd1;

  if (!acc_w_ok(NUM_LANES, DATA_W, ACC_W)) begin : g_acc_w_check
    $error("mac_array_accum: ACC_W too narrow for NUM_LANES x DATA_W products");
  end

  logic signed [PROD_W-1:0] prod_s [NUM_LANES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mac_array_accum_lane #(.DATA_W(DATA_W)) u_lane (
      .en      (bus.in_mask[i]),
      .feature (bus.in_feature[i*DATA_W +: DATA_W]),
      .weight  (bus.in_weight[i*DATA_W +: DATA_W]),
      .product (prod_s[i])
    );
  end

  logic signed [SUM_W-1:0] sum_s;

  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum_s = sum_s + SUM_W'(prod_s[i]);
    end
  end

  mac_state_e               state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic                     relu_q, relu_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic [ACC_W-1:0]         out_acc_q, out_acc_d;

  logic signed [63:0] addend_s, acc_sum_s, acc_clip_s, q_s, q_clip_s;
  logic               acc_ovf_s, q_ovf_s, accept_s;

  // The single shared adder takes the landed beat sum, or the aligned bias in BIAS.
  always_comb begin
    if (state_q == ST_BIAS) begin
      addend_s = 64'(bias_q) <<< FRAC_SHIFT;
    end else begin
      addend_s = 64'(sum_q);
    end
    acc_sum_s  = 64'(acc_q) + addend_s;
    acc_clip_s = sat_clip(acc_sum_s, ACC_MIN, ACC_MAX);
    acc_ovf_s  = (acc_clip_s != acc_sum_s);
    q_s        = acc_clip_s >>> FRAC_SHIFT;
    if (!relu_q) begin
      q_clip_s = sat_clip(q_s, Q_MIN_S, Q_MAX_S);
      q_ovf_s  = (q_clip_s != q_s);
    end else if (q_s < 64'sd0) begin
      q_clip_s = 64'sd0;
      q_ovf_s  = 1'b0;
    end else begin
      q_clip_s = sat_clip(q_s, 64'sd0, Q_MAX_U);
      q_ovf_s  = (q_clip_s != q_s);
    end
  end

  assign accept_s = (state_q == ST_ACC) && in_ready_q && bus.in_valid;

  always_comb begin
    state_d    = state_q;
    sum_d      = '0;
    acc_d      = acc_q;
    sat_d      = sat_q;
    bias_d     = bias_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    out_acc_d  = out_acc_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_d = acc_clip_s[ACC_W-1:0];
        sat_d = sat_q | acc_ovf_s;
        if (accept_s) begin
          sum_d = sum_s;
          if (bus.in_last) begin
            state_d = ST_DRAIN;
            bias_d  = bus.bias;
            relu_d  = bus.relu_en;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          sum_d = '0;
        end
      end
      ST_DRAIN: begin
        acc_d   = acc_clip_s[ACC_W-1:0];
        sat_d   = sat_q | acc_ovf_s;
        state_d = ST_BIAS;
      end
      ST_BIAS: begin
        acc_d      = acc_clip_s[ACC_W-1:0];
        sat_d      = sat_q | acc_ovf_s;
        out_acc_d  = acc_clip_s[ACC_W-1:0];
        out_data_d = q_clip_s[DATA_W-1:0];
        out_sat_d  = sat_q | acc_ovf_s | q_ovf_s;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d    = ST_ACC;
          acc_d      = '0;
          sat_d      = 1'b0;
          out_data_d = '0;
          out_sat_d  = 1'b0;
          out_acc_d  = '0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any beat or handshake in the same cycle.
    if (clear) begin
      state_d    = ST_ACC;
      sum_d      = '0;
      acc_d      = '0;
      sat_d      = 1'b0;
      out_data_d = '0;
      out_sat_d  = 1'b0;
      out_acc_d  = '0;
    end else begin
      sum_d = sum_d;
    end

    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_acc_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_acc_q   <= out_acc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_acc   = out_acc_q;

endmodule
